// File: rtl/pb_uart_pkg.sv
// Shared UART types: FSM states, per-frame configuration and frame constants.
// Used by the TX block now and by the RX block later.
package pb_uart_pkg;

    localparam int unsigned DataBits    = 8;
    localparam int unsigned CfgDivWidth = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // div holds the effective clocks per bit, already clamped to at least 1
    typedef struct packed {
        logic [CfgDivWidth-1:0] div;
        logic                   parity_en;
        logic                   parity_odd;
        logic                   stop2;
    } uart_cfg_t;

endpackage

// File: rtl/pb_uart_tx_fifo.sv
// Byte FIFO with a synchronous reset and power-of-two depth.
// Each pointer carries an extra wrap bit, so full and empty can be told apart.
module pb_uart_tx_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   usage
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW:0]   wr_ptr;
    logic [AddrW:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign usage   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                     (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
    assign rdata   = mem[rd_ptr[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AddrW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AddrW+1)'(1);
        end
    end

    // Storage carries no reset; a slot only becomes visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AddrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pb_uart_tx.sv
// UART transmitter: buffers host bytes in a FIFO and serialises them LSB-first
// as 8N1/8E1/8O1 frames with one or two stop bits. Frame config is latched at pop.
module pb_uart_tx
    import pb_uart_pkg::*;
#(
    parameter int unsigned FifoDepth = 16,
    parameter int unsigned DivWidth  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DivWidth-1:0]            cfg_div_i,
    input  logic                           cfg_parity_en_i,
    input  logic                           cfg_parity_odd_i,
    input  logic                           cfg_stop2_i,
    input  logic [DataBits-1:0]            data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           tx_o,
    output logic                           idle_o,
    output logic [$clog2(FifoDepth):0]     usage_o
);

    localparam int unsigned IdxW = $clog2(DataBits);

    tx_state_e           state_q, state_d;
    uart_cfg_t           cfg_q, cfg_d;
    logic [DivWidth-1:0] bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                stop_second_q, stop_second_d;
    logic                tx_q, tx_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DataBits-1:0] fifo_rdata;
    logic [DivWidth-1:0] new_div;
    logic [DivWidth-1:0] frame_div_m1;
    logic                bit_done;

    pb_uart_tx_fifo #(
        .Depth (FifoDepth),
        .Width (DataBits)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .wdata (data_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .usage (usage_o)
    );

    assign ready_o      = ~rst_i & ~fifo_full;
    assign fifo_push    = valid_i & ready_o;
    assign idle_o       = fifo_empty & (state_q == IDLE);
    assign tx_o         = tx_q;
    assign bit_done     = (bit_cnt_q == '0);
    assign new_div      = (cfg_div_i == '0) ? DivWidth'(1) : cfg_div_i;
    assign frame_div_m1 = DivWidth'(cfg_q.div) - DivWidth'(1);

    // Next-state, bit timing and line level for the following cycle.
    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        bit_cnt_d     = bit_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        stop_second_d = stop_second_q;
        tx_d          = tx_q;
        fifo_pop      = 1'b0;

        if (!bit_done) begin
            bit_cnt_d = bit_cnt_q - DivWidth'(1);
        end else if (state_q != IDLE) begin
            bit_cnt_d = frame_div_m1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                fifo_pop = ~fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_idx_d = bit_idx_q + IdxW'(1);
                    if (bit_idx_q == IdxW'(DataBits - 1)) begin
                        stop_second_d = 1'b0;
                        if (cfg_q.parity_en) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d       = STOP;
                    tx_d          = 1'b1;
                    stop_second_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (cfg_q.stop2 && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop starts the next frame immediately, from IDLE or from the last stop bit.
        if (fifo_pop) begin
            state_d          = START;
            tx_d             = 1'b0;
            shift_d          = fifo_rdata;
            parity_d         = (^fifo_rdata) ^ cfg_parity_odd_i;
            cfg_d.div        = CfgDivWidth'(new_div);
            cfg_d.parity_en  = cfg_parity_en_i;
            cfg_d.parity_odd = cfg_parity_odd_i;
            cfg_d.stop2      = cfg_stop2_i;
            bit_cnt_d        = new_div - DivWidth'(1);
        end

        if (state_d == IDLE) bit_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            stop_second_q <= 1'b0;
            tx_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            stop_second_q <= stop_second_d;
            tx_q          <= tx_d;
        end
    end

endmodule

// File: tb/tb_pb_uart_tx.sv
// Bench for pb_uart_tx: accepted bytes queue their expected frames, and a
// cycle-accurate line monitor pops and checks every bit level and bit length.
module tb_pb_uart_tx;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
        logic        par_en;
        logic        par_odd;
        logic        stop2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        tx;
    logic        idle;
    logic [4:0]  usage;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    int   idle_run = 0;
    int   gap_sum = 0;
    int   mon_frames = 0;

    pb_uart_tx #(
        .FifoDepth (16),
        .DivWidth  (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (par_en),
        .cfg_parity_odd_i (par_odd),
        .cfg_stop2_i      (stop2),
        .data_i           (data),
        .valid_i          (valid),
        .ready_o          (ready),
        .tx_o             (tx),
        .idle_o           (idle),
        .usage_o          (usage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic frame_bit(input exp_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (e.par_en && b == 9) return (^e.data) ^ e.par_odd;
        return 1'b1;
    endfunction

    // Offer one byte for up to tmo cycles; on acceptance queue the expected frame.
    task automatic push(input logic [7:0] d, input int tmo, input logic [15:0] exp_div,
                        output bit acc, output int waits);
        exp_t e;
        acc   = 1'b0;
        waits = 0;
        valid = 1'b1;
        data  = d;
        for (int i = 0; i < tmo; i++) begin
            acc = ready;
            @(posedge clk);
            if (acc) begin
                e.data    = d;
                e.div     = exp_div;
                e.par_en  = par_en;
                e.par_odd = par_odd;
                e.stop2   = stop2;
                exp_q.push_back(e);
            end
            @(negedge clk);
            if (acc) break;
            waits++;
        end
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_n, input int limit);
        int n = 0;
        while (!idle && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    // Line monitor: each frame bit must hold its level for exactly div cycles.
    initial begin : monitor
        exp_t m_e;
        int   m_nb;
        int   m_dv;
        logic m_bit;
        logic m_obs;
        bit   m_bad;
        bit   m_abort;
        forever begin
            @(posedge clk);
            #1;
            if (rst || tx !== 1'b0) begin
                if (!rst) idle_run++;
            end else if (exp_q.size() == 0) begin
                check("unexpected_start", 32'(tx), 32'(1));
            end else begin
                m_e = exp_q.pop_front();
                if (mon_frames > 0) gap_sum += idle_run;
                idle_run = 0;
                mon_frames++;
                m_nb    = 10 + int'(m_e.par_en) + int'(m_e.stop2);
                m_dv    = (m_e.div == 16'd0) ? 1 : int'(m_e.div);
                m_abort = 1'b0;
                for (int b = 0; b < m_nb && !m_abort; b++) begin
                    m_bit = frame_bit(m_e, b);
                    m_obs = m_bit;
                    m_bad = 1'b0;
                    for (int c = 0; c < m_dv; c++) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (rst) begin
                            m_abort = 1'b1;
                            break;
                        end
                        if (tx !== m_bit && !m_bad) begin
                            m_bad = 1'b1;
                            m_obs = tx;
                        end
                    end
                    if (!m_abort)
                        check($sformatf("d%02h_bit%0d", m_e.data, b), 32'(m_obs), 32'(m_bit));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit acc;
        int w;
        int n_acc;
        rst     = 1'b1;
        valid   = 1'b0;
        data    = 8'h00;
        cfg_div = 16'd4;
        par_en  = 1'b0;
        par_odd = 1'b0;
        stop2   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_idle", 32'(idle), 32'(1));
        check("rst_usage", 32'(usage), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'(1));

        // 8N1 at 4 clocks per bit
        push(8'h55, 4, 16'd4, acc, w);
        check("t1_acc", 32'(acc), 32'(1));
        wait_idle("t1_idle_at", 41, 200);

        // parity even, odd, then odd with two stop bits
        cfg_div = 16'd2;
        par_en  = 1'b1;
        push(8'hA3, 4, 16'd2, acc, w);
        wait_idle("t2_even_idle_at", 23, 100);
        par_odd = 1'b1;
        push(8'hA3, 4, 16'd2, acc, w);
        wait_idle("t2_odd_idle_at", 23, 100);
        stop2 = 1'b1;
        push(8'hA3, 4, 16'd2, acc, w);
        wait_idle("t2_stop2_idle_at", 25, 100);
        par_en  = 1'b0;
        par_odd = 1'b0;
        stop2   = 1'b0;

        // divisor 0 behaves as 1
        cfg_div = 16'd0;
        push(8'h00, 4, 16'd0, acc, w);
        wait_idle("t5_idle_at", 11, 100);

        // fill the FIFO at 100 clocks per bit
        cfg_div    = 16'd100;
        mon_frames = 0;
        gap_sum    = 0;
        n_acc      = 0;
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h10 + i), 1, 16'd100, acc, w);
            if (acc) n_acc++;
        end
        check("t3_accepted", 32'(n_acc), 32'(17));
        check("t3_usage_full", 32'(usage), 32'(16));
        check("t3_ready_full", 32'(ready), 32'(0));
        push(8'hEE, 2000, 16'd100, acc, w);
        check("t3_late_acc", 32'(acc), 32'(1));
        check("t3_late_wait", 32'(w), 32'(982));
        wait_idle("t3_idle_at", 16999, 20000);
        check("t3_frames", 32'(mon_frames), 32'(18));
        check("t3_gap", 32'(gap_sum), 32'(0));

        // divisor change mid-frame only affects the next pop
        cfg_div = 16'd4;
        push(8'h3C, 4, 16'd4, acc, w);
        push(8'hC3, 4, 16'd16, acc, w);
        cfg_div = 16'd16;
        wait_idle("t6_idle_at", 200, 400);

        // reset mid-DATA with bytes still queued
        cfg_div = 16'd8;
        push(8'hF0, 4, 16'd8, acc, w);
        for (int i = 0; i < 3; i++) push(8'(8'hA0 + i), 4, 16'd8, acc, w);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_rst_tx", 32'(tx), 32'(1));
        check("t4_rst_usage", 32'(usage), 32'(0));
        check("t4_rst_idle", 32'(idle), 32'(1));
        check("t4_rst_ready", 32'(ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        push(8'h0F, 4, 16'd8, acc, w);
        check("t4_post_acc", 32'(acc), 32'(1));
        wait_idle("t4_idle_at", 81, 300);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
